vector_minmax_stream_unit: RTL and testbench
============================================

Name: vector_minmax_stream_unit

Overview:
- Pipelined, parametrised successor to the combinational vector min/max unit.
- Performs element-wise vmin/vminu/vmax/vmaxu over a DATA_WIDTH-bit beat at SEW 8/16/32/64.
- Adds multi-beat reductions (vredmin/vredminu/vredmax/vredmaxu) with a running accumulator.
- Sits between the vector register read stage and writeback, with valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 128, beat width in bits; multiple of 64, minimum 64.
- LANES64, DATA_WIDTH/64, derived (localparam); number of 64-bit lanes.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  beat offered.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- op  input  2  00 min (signed), 01 minu, 10 max (signed), 11 maxu.
- sew  input  2  00 = 8, 01 = 16, 10 = 32, 11 = 64 bits.
- reduce  input  1  0 = element-wise, 1 = reduction beat.
- first  input  1  first beat of a reduction.
- last  input  1  last beat of a reduction.
- vs2  input  DATA_WIDTH  source operand / reduction data.
- vs1  input  DATA_WIDTH  source operand; element 0 is the reduction seed on the first beat.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- vd  output  DATA_WIDTH  result.

Behaviour:
- Reset: out_valid = 0, vd = 0, accumulator = 0, FSM = IDLE, both pipeline stages invalid. in_ready = 1 in the cycle after reset deasserts.
- Pipeline: S1 registers lane compare results, or the in-beat tree reduction of vs2 elements. S2 merges into the accumulator and drives the vd/out_valid registers.
- Stall: in_ready = !S1_valid || advance, where advance = !S2_valid || out_ready. The whole pipe stalls together; no bubble insertion.
- Element-wise: vd element i = op(vs2[i], vs1[i]) at the selected SEW. Ties select vs1. Latency is 2 cycles from acceptance to out_valid, with no stall.
- Reduction: N = DATA_WIDTH/SEW elements per beat. Each beat is tree-reduced in S1.
  - S2 combines: acc = op(acc_or_seed, beat_result).
  - Seed = vs1 element 0 when first = 1.
  - Non-last beats produce no output.
  - On the last beat, vd[SEW-1:0] = final result and all bits above SEW are 0. out_valid rises 2 cycles after the last beat is accepted.
- Signed ops compare two's complement per element; unsigned ops compare magnitude. Per-element results carry no cross-element influence.
- FSM states:
  - IDLE: a reduce&first beat goes to ACCUM; a reduce&first&last beat stays IDLE and emits a result; a reduce beat without first is treated as first.
  - ACCUM: a reduce&last beat returns to IDLE and emits a result; a reduce&first beat restarts (old acc is discarded and reseeded); an element-wise beat is processed normally and the acc is retained.
  - op/sew are sampled per beat; the first beat's values govern the whole reduction.
- Simultaneous last-beat output with out_ready = 0: the result holds, vd is stable, and the pipe stalls.
- Synchronous reset mid-operation discards the open reduction and all in-flight beats within that cycle.

Optional Feature:
- Macro VMINMAX_MASK_EN.
- When defined, adds ports mask (input, DATA_WIDTH/8; bit i masks element i) and vd_old (input, DATA_WIDTH).
  - Element-wise: a masked-off element i takes vd_old[i] (mask-undisturbed).
  - Reduction: masked-off elements are excluded from the tree. A fully masked beat leaves acc unchanged; a fully masked reduction returns the seed.
  - Only mask bits [N-1:0] are used at the current SEW.
- When undefined, the ports are absent and all elements are active.

Decomposition:
- Shared package dragonfang_pkg holds:
  - minmax_op_t enum (MIN, MINU, MAX, MAXU).
  - sew_t enum (SEW8..SEW64).
  - function sew_bits().
  - reduction_state_t enum (IDLE, ACCUM).
- Sub-module minmax_lane64: one 64-bit SIMD compare/select lane for op and sew. It is instantiated LANES64 times and reused in the tree-reduction stage.

Test Plan:
- Element-wise min, sew = 8, vs2 byte0 = 0x80, vs1 byte0 = 0x7F -> vd byte0 = 0x80 two cycles after acceptance. Same bytes with minu -> 0x7F.
- Element-wise maxu, sew = 64, DATA_WIDTH = 128, vs2 = {0x1, 0xFFFF_FFFF_FFFF_FFFF}, vs1 = {0x2, 0x0} -> vd = {0x2, 0xFFFF_FFFF_FFFF_FFFF}.
- Reduction vredmax, sew = 32, seed = -5, beats with elements {3, -7, 12, 0} then {-1, 40, 2, 9} (first/last flagged) -> single output, vd[31:0] = 40, upper bits 0; no output after beat 1.
- Backpressure: out_ready held 0 for 5 cycles during 4 element-wise beats -> in_ready drops after 2 beats, vd is held stable, and all 4 results emerge in order with none lost.
- Reset asserted in ACCUM after 1 of 3 reduction beats -> out_valid = 0 the next cycle; a following fresh reduction seeded with 7 over all-zero beats (vredminu) yields 0.
- VMINMAX_MASK_EN: vredmin sew = 16, seed = 100, beat values {5, 50, -3, 8}, mask = 0b1010 -> result 8. Element-wise with mask = 0 -> vd == vd_old.

Source files
------------

// File: rtl/dragonfang_pkg.sv
// Shared types and helpers for the vector min/max stream unit.
package dragonfang_pkg;

  typedef enum logic [1:0] {
    MIN  = 2'b00,
    MINU = 2'b01,
    MAX  = 2'b10,
    MAXU = 2'b11
  } minmax_op_t;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10,
    SEW64 = 2'b11
  } sew_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } reduction_state_t;

  function automatic int unsigned sew_bits(input sew_t s);
    return 32'd8 << s;
  endfunction

  function automatic logic [63:0] low_mask64(input sew_t s);
    return (s == SEW64) ? '1 : ((64'd1 << sew_bits(s)) - 64'd1);
  endfunction

  // Signed compares flip the element sign bit so a single unsigned compare serves both.
  function automatic logic [63:0] pick(input logic [63:0] a, input logic [63:0] b,
                                       input int unsigned w, input minmax_op_t o);
    logic [63:0] m, sb, ka, kb;
    logic        take_a;
    m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sb = (o == MIN || o == MAX) ? (64'd1 << (w - 1)) : 64'd0;
    ka = (a & m) ^ sb;
    kb = (b & m) ^ sb;
    take_a = (o == MIN || o == MINU) ? (ka < kb) : (ka > kb);
    return take_a ? (a & m) : (b & m);
  endfunction

endpackage

// File: rtl/vector_minmax_stream_unit_lane64.sv
// One 64-bit SIMD compare/select lane; ties select b_i.
module minmax_lane64
  import dragonfang_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  minmax_op_t  op_i,
  input  sew_t        sew_i,
  output logic [63:0] y_o
);

  always_comb begin
    y_o = '0;
    case (sew_i)
      SEW8:  for (int i = 0; i < 8; i++)
               y_o[i*8 +: 8] = 8'(pick(64'(a_i[i*8 +: 8]), 64'(b_i[i*8 +: 8]), 8, op_i));
      SEW16: for (int i = 0; i < 4; i++)
               y_o[i*16 +: 16] = 16'(pick(64'(a_i[i*16 +: 16]), 64'(b_i[i*16 +: 16]), 16, op_i));
      SEW32: for (int i = 0; i < 2; i++)
               y_o[i*32 +: 32] = 32'(pick(64'(a_i[i*32 +: 32]), 64'(b_i[i*32 +: 32]), 32, op_i));
      default: y_o = pick(a_i, b_i, 64, op_i);
    endcase
  end

endmodule

// File: rtl/vector_minmax_stream_unit.sv
// Two-stage vector min/max unit: element-wise ops and multi-beat reductions.
// Define VMINMAX_MASK_EN to add mask / vd_old ports (mask-undisturbed elements).
module vector_minmax_stream_unit
  import dragonfang_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              op,
  input  logic [1:0]              sew,
  input  logic                    reduce,
  input  logic                    first,
  input  logic                    last,
  input  logic [DATA_WIDTH-1:0]   vs2,
  input  logic [DATA_WIDTH-1:0]   vs1,
`ifdef VMINMAX_MASK_EN
  input  logic [DATA_WIDTH/8-1:0] mask,
  input  logic [DATA_WIDTH-1:0]   vd_old,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   vd
);
  localparam int LANES64 = DATA_WIDTH / 64;

  reduction_state_t      state_q, state_d;
  minmax_op_t            red_op_q, op_e, op_p1_q;
  sew_t                  red_sew_q, sew_e, sew_p1_q;
  logic                  accept, beat_first, advance;
  logic                  vld_p1_q, red_p1_q, first_p1_q, last_p1_q;
  logic [DATA_WIDTH-1:0] data_p1_q, ew_vec, ew_final, red_src;
  logic [63:0]           seed_p1_q, tree_raw, tree_res, f32, f16, f8;
  logic                  vld_p2_q;
  logic [DATA_WIDTH-1:0] vd_p2_q;
  logic [63:0]           acc_p2_q, comb_base, comb_raw, comb_res;

  assign advance    = !vld_p2_q || out_ready;
  assign in_ready   = !vld_p1_q || advance;
  assign accept     = in_valid && in_ready;
  assign beat_first = reduce && (first || state_q == IDLE);
  // Continuation beats of a reduction follow the op/sew captured on its first beat.
  assign op_e  = (reduce && !beat_first) ? red_op_q  : minmax_op_t'(op);
  assign sew_e = (reduce && !beat_first) ? red_sew_q : sew_t'(sew);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept && reduce) state_d = last ? IDLE : ACCUM;
  end

`ifdef VMINMAX_MASK_EN
  function automatic logic [DATA_WIDTH-1:0] expand_mask(input logic [DATA_WIDTH/8-1:0] m,
                                                        input sew_t s);
    logic [DATA_WIDTH-1:0] e;
    int unsigned           w;
    w = sew_bits(s);
    for (int unsigned b = 0; b < DATA_WIDTH; b++) e[b] = m[b / w];
    return e;
  endfunction

  // Neutral element per op, so masked-off elements cannot win the reduction.
  function automatic logic [DATA_WIDTH-1:0] identity_vec(input minmax_op_t o, input sew_t s);
    logic [DATA_WIDTH-1:0] v;
    int unsigned           w;
    w = sew_bits(s);
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      case (o)
        MINU:    v[b] = 1'b1;
        MAXU:    v[b] = 1'b0;
        MIN:     v[b] = ((b % w) != (w - 1));
        default: v[b] = ((b % w) == (w - 1));
      endcase
    end
    return v;
  endfunction

  logic [DATA_WIDTH-1:0] en_bits;
  assign en_bits  = expand_mask(mask, sew_e);
  assign red_src  = (vs2 & en_bits) | (identity_vec(op_e, sew_e) & ~en_bits);
  assign ew_final = (ew_vec & en_bits) | (vd_old & ~en_bits);
`else
  assign red_src  = vs2;
  assign ew_final = ew_vec;
`endif

  for (genvar l = 0; l < LANES64; l++) begin : g_lane
    logic [63:0] link;
    minmax_lane64 u_ew (.a_i(vs2[l*64 +: 64]), .b_i(vs1[l*64 +: 64]), .op_i(op_e),
                        .sew_i(sew_e), .y_o(ew_vec[l*64 +: 64]));
    if (l == 0) begin : g_head
      assign link = red_src[63:0];
    end else begin : g_link
      minmax_lane64 u_red (.a_i(g_lane[l-1].link), .b_i(red_src[l*64 +: 64]), .op_i(op_e),
                           .sew_i(sew_e), .y_o(link));
    end
  end

  // Fold the combined 64-bit word in halves until one element remains.
  minmax_lane64 u_f32 (.a_i(g_lane[LANES64-1].link), .b_i(g_lane[LANES64-1].link >> 32),
                       .op_i(op_e), .sew_i(sew_e), .y_o(f32));
  minmax_lane64 u_f16 (.a_i(f32), .b_i(f32 >> 16), .op_i(op_e), .sew_i(sew_e), .y_o(f16));
  minmax_lane64 u_f8  (.a_i(f16), .b_i(f16 >> 8),  .op_i(op_e), .sew_i(sew_e), .y_o(f8));

  always_comb begin
    case (sew_e)
      SEW64:   tree_raw = g_lane[LANES64-1].link;
      SEW32:   tree_raw = f32;
      SEW16:   tree_raw = f16;
      default: tree_raw = f8;
    endcase
    tree_res = tree_raw & low_mask64(sew_e);
  end

  // ---- Stage 1: lane results or per-beat reduction ----
  always_ff @(posedge clk) begin
    if (reset)         vld_p1_q <= 1'b0;
    else if (in_ready) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1_q  <= reduce ? DATA_WIDTH'(tree_res) : ew_final;
      red_p1_q   <= reduce;
      first_p1_q <= beat_first;
      last_p1_q  <= last;
      op_p1_q    <= op_e;
      sew_p1_q   <= sew_e;
      seed_p1_q  <= vs1[63:0] & low_mask64(sew_e);
      if (beat_first) begin
        red_op_q  <= op_e;
        red_sew_q <= sew_e;
      end
    end
  end

  // ---- Stage 2: accumulator merge and output register ----
  assign comb_base = first_p1_q ? seed_p1_q : acc_p2_q;
  minmax_lane64 u_comb (.a_i(comb_base), .b_i(data_p1_q[63:0]), .op_i(op_p1_q),
                        .sew_i(sew_p1_q), .y_o(comb_raw));
  assign comb_res = comb_raw & low_mask64(sew_p1_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q <= 1'b0;
      vd_p2_q  <= '0;
      acc_p2_q <= '0;
    end else if (advance) begin
      vld_p2_q <= vld_p1_q && (!red_p1_q || last_p1_q);
      if (vld_p1_q) begin
        if (red_p1_q) begin
          acc_p2_q <= comb_res;
          if (last_p1_q) vd_p2_q <= DATA_WIDTH'(comb_res);
        end else begin
          vd_p2_q <= data_p1_q;
        end
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign vd        = vd_p2_q;

endmodule

// File: tb/tb_vector_minmax_stream_unit.sv
// Randomized self-checking bench for vector_minmax_stream_unit against a behavioural model.
module tb_vector_minmax_stream_unit;
  localparam int DW = 128;

  logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready;
  logic          reduce = 1'b0, first = 1'b0, last = 1'b0, out_valid, out_ready = 1'b1;
  logic [1:0]    op = 2'b00, sew = 2'b00;
  logic [DW-1:0] vs2 = '0, vs1 = '0, vd;
`ifdef VMINMAX_MASK_EN
  logic [DW/8-1:0] mask = '1;
  logic [DW-1:0]   vd_old = '0;
`endif
  int            tests = 0, fails = 0;
  logic [DW-1:0] got_q[$], exp_q[$];

  vector_minmax_stream_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .sew(sew),
    .reduce(reduce), .first(first), .last(last), .vs2(vs2), .vs1(vs1),
`ifdef VMINMAX_MASK_EN
    .mask(mask), .vd_old(vd_old),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .vd(vd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && out_valid && out_ready) got_q.push_back(vd);

  // ---------------- reference model ----------------
  function automatic logic [63:0] elem(input logic [DW-1:0] v, input int w, input int i);
    logic [DW-1:0] t;
    t = v >> (i * w);
    return (w == 64) ? t[63:0] : (t[63:0] & ((64'd1 << w) - 64'd1));
  endfunction

  function automatic logic [63:0] m_op(input logic [63:0] a, input logic [63:0] b,
                                       input int w, input logic [1:0] o);
    longint sa, sb;
    logic   take_a;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    case (o)
      2'b00:   take_a = sa < sb;
      2'b01:   take_a = a < b;
      2'b10:   take_a = sa > sb;
      default: take_a = a > b;
    endcase
    return take_a ? a : b;
  endfunction

  function automatic logic [DW-1:0] m_ew(input logic [1:0] o, input logic [1:0] s,
                                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    int            w;
    logic [DW-1:0] r;
    w = 8 << s;
    r = '0;
    for (int i = 0; i < DW / w; i++) r |= DW'(m_op(elem(a, w, i), elem(b, w, i), w, o)) << (i * w);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 8; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*8 +: 8] = 8'h80;
        1:       v[i*8 +: 8] = 8'h7F;
        2:       v[i*8 +: 8] = 8'hFF;
        3:       v[i*8 +: 8] = 8'h00;
        default: v[i*8 +: 8] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [1:0] o, input logic [1:0] s, input logic r, input logic f,
                       input logic l, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int c;
    op = o; sew = s; reduce = r; first = f; last = l; vs2 = a; vs1 = b; in_valid = 1'b1;
    c = 0;
    @(negedge clk);
    while (!in_ready && c < 300) begin @(negedge clk); c++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL drive_accept in_ready=%b required 1 within 300 cycles", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_outputs(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 600) begin @(posedge clk); #1; c++; end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
    tests++; if (vd !== '0) begin fails++; $display("FAIL reset_vd got %h need 0", vd); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b need 1", in_ready); end
  endtask

  task automatic test_elementwise();
    logic [DW-1:0] a, b, e;
    // min / minu at sew 8, with 2-cycle latency
    for (int k = 0; k < 2; k++) begin
      a = DW'(8'h80); b = DW'(8'h7F);
      e = (k == 0) ? DW'(8'h80) : DW'(8'h7F);
      drive(2'(k), 2'b00, 1'b0, 1'b0, 1'b0, a, b);
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ew_latency_early[%0d] out_valid=%b need 0", k, out_valid); end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || vd !== e) begin
        fails++; $display("FAIL ew_sew8[%0d] out_valid=%b vd=%h need 1 %h", k, out_valid, vd, e);
      end
      @(posedge clk); #1;
    end
    a = {64'h1, 64'hFFFF_FFFF_FFFF_FFFF};
    b = {64'h2, 64'h0};
    drive(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, a, b);
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (vd !== {64'h2, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      fails++; $display("FAIL ew_maxu64 got %h need %h", vd, {64'h2, 64'hFFFF_FFFF_FFFF_FFFF});
    end
    @(posedge clk); #1;
    got_q.delete();
  endtask

  task automatic test_elementwise_random();
    logic [DW-1:0] a, b;
    logic [1:0]    o, s;
    got_q.delete(); exp_q.delete();
    for (int t = 0; t < 24; t++) begin
      a = rand_vec(); b = (t % 6 == 5) ? a : rand_vec();
      o = 2'($urandom); s = 2'($urandom);
      exp_q.push_back(m_ew(o, s, a, b));
      drive(o, s, 1'b0, 1'($urandom), 1'($urandom), a, b);
    end
    in_valid = 1'b0;
    wait_outputs(exp_q.size());
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL ew_rand_count got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL ew_rand[%0d] got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reduction();
    logic [DW-1:0] b1, b2, seed;
    got_q.delete();
    seed = DW'(32'hFFFF_FFFB);
    b1 = {32'd0, 32'd12, 32'hFFFF_FFF9, 32'd3};
    b2 = {32'd9, 32'd2, 32'd40, 32'hFFFF_FFFF};
    drive(2'b10, 2'b10, 1'b1, 1'b1, 1'b0, b1, seed);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL red_no_early_out got %0d outputs need 0", got_q.size()); end
    drive(2'b10, 2'b10, 1'b1, 1'b0, 1'b1, b2, rand_vec());
    in_valid = 1'b0;
    wait_outputs(1);
    tests++; if (got_q.size() != 1) begin fails++; $display("FAIL red_count got %0d need 1", got_q.size()); end
    tests++;
    if (got_q.size() > 0 && got_q[0] !== DW'(40)) begin
      fails++; $display("FAIL red_vredmax got %h need %h", got_q[0], DW'(40));
    end
  endtask

  task automatic test_reduction_random();
    logic [DW-1:0] a, b, ea, eb;
    logic [1:0]    o, s, eo, es;
    logic [63:0]   acc;
    logic          abandon, mid_ew, f;
    int            w, nb;
    got_q.delete(); exp_q.delete();
    for (int t = 0; t < 16; t++) begin
      o = 2'($urandom); s = 2'($urandom); w = 8 << s;
      nb = $urandom_range(1, 3);
      abandon = ($urandom_range(0, 2) == 0);
      mid_ew  = (nb > 1) && ($urandom_range(0, 2) == 0);
      if (abandon) drive(2'($urandom), 2'($urandom), 1'b1, 1'b1, 1'b0, rand_vec(), rand_vec());
      acc = '0;
      for (int j = 0; j < nb; j++) begin
        a = rand_vec(); b = rand_vec();
        if (j == 0) begin
          f = abandon ? 1'b1 : 1'($urandom);
          drive(o, s, 1'b1, f, 1'(j == nb - 1), a, b);
          acc = elem(b, w, 0);
        end else begin
          drive(2'($urandom), 2'($urandom), 1'b1, 1'b0, 1'(j == nb - 1), a, b);
        end
        for (int i = 0; i < DW / w; i++) acc = m_op(acc, elem(a, w, i), w, o);
        if (mid_ew && j == 0) begin
          ea = rand_vec(); eb = rand_vec(); eo = 2'($urandom); es = 2'($urandom);
          drive(eo, es, 1'b0, 1'b0, 1'b0, ea, eb);
          exp_q.push_back(m_ew(eo, es, ea, eb));
        end
      end
      exp_q.push_back(DW'(acc));
    end
    in_valid = 1'b0;
    wait_outputs(exp_q.size());
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL red_rand_count got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL red_rand[%0d] got %h need %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a[4], b[4], e[4];
    logic [1:0]    o[4], s[4];
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      a[i] = rand_vec(); b[i] = rand_vec(); o[i] = 2'($urandom); s[i] = 2'($urandom);
      e[i] = m_ew(o[i], s[i], a[i], b[i]);
    end
    out_ready = 1'b0;
    drive(o[0], s[0], 1'b0, 1'b0, 1'b0, a[0], b[0]);
    drive(o[1], s[1], 1'b0, 1'b0, 1'b0, a[1], b[1]);
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b need 0", in_ready); end
    tests++;
    if (out_valid !== 1'b1 || vd !== e[0]) begin
      fails++; $display("FAIL bp_head out_valid=%b vd=%h need 1 %h", out_valid, vd, e[0]);
    end
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (out_valid !== 1'b1 || vd !== e[0]) begin
      fails++; $display("FAIL bp_hold out_valid=%b vd=%h need 1 %h", out_valid, vd, e[0]);
    end
    out_ready = 1'b1;
    drive(o[2], s[2], 1'b0, 1'b0, 1'b0, a[2], b[2]);
    drive(o[3], s[3], 1'b0, 1'b0, 1'b0, a[3], b[3]);
    in_valid = 1'b0;
    wait_outputs(4);
    tests++; if (got_q.size() != 4) begin fails++; $display("FAIL bp_count got %0d need 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== e[i]) begin fails++; $display("FAIL bp_order[%0d] got %h need %h", i, got_q[i], e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a, b;
    logic [1:0]    o, s;
    logic          done;
    got_q.delete(); exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int t = 0; t < 30; t++) begin
          a = rand_vec(); b = rand_vec(); o = 2'($urandom); s = 2'($urandom);
          exp_q.push_back(m_ew(o, s, a, b));
          drive(o, s, 1'b0, 1'b0, 1'b0, a, b);
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = 1'($urandom); end
        out_ready = 1'b1;
      end
    join
    wait_outputs(exp_q.size());
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_count got %0d need %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b[%0d] got %h need %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    out_ready = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, rand_vec(), rand_vec());
    drive(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, rand_vec(), DW'(8'h03));
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got %b need 0", out_valid); end
    out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL rstmid_flushed got %0d outputs need 0", got_q.size()); end
    drive(2'b01, 2'b00, 1'b1, 1'b1, 1'b0, '0, DW'(8'd7));
    drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, '0, rand_vec());
    drive(2'b01, 2'b00, 1'b1, 1'b0, 1'b1, '0, rand_vec());
    in_valid = 1'b0;
    wait_outputs(1);
    tests++; if (got_q.size() != 1) begin fails++; $display("FAIL rstmid_count got %0d need 1", got_q.size()); end
    tests++;
    if (got_q.size() > 0 && got_q[0] !== '0) begin
      fails++; $display("FAIL rstmid_vredminu got %h need 0", got_q[0]);
    end
  endtask

`ifdef VMINMAX_MASK_EN
  task automatic test_mask();
    logic [DW-1:0] old_v;
    got_q.delete();
    mask = 16'b1010;
    drive(2'b00, 2'b01, 1'b1, 1'b1, 1'b1,
          {16'd1, 16'd1, 16'd1, 16'd1, 16'd8, 16'hFFFD, 16'd50, 16'd5}, DW'(16'd100));
    mask = '0;
    old_v = rand_vec(); vd_old = old_v;
    drive(2'($urandom), 2'($urandom), 1'b0, 1'b0, 1'b0, rand_vec(), rand_vec());
    in_valid = 1'b0;
    wait_outputs(2);
    mask = '1;
    tests++; if (got_q.size() != 2) begin fails++; $display("FAIL mask_count got %0d need 2", got_q.size()); end
    tests++;
    if (got_q.size() > 0 && got_q[0] !== DW'(8)) begin fails++; $display("FAIL mask_red got %h need %h", got_q[0], DW'(8)); end
    tests++;
    if (got_q.size() > 1 && got_q[1] !== old_v) begin fails++; $display("FAIL mask_ew got %h need %h", got_q[1], old_v); end
  endtask
`endif

  initial begin
    test_reset();
    test_elementwise();
    test_elementwise_random();
    test_reduction();
    test_reduction_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef VMINMAX_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
